// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// CLA_OVERFLOW_FLAG_EN adds the signed-overflow flag ovf.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVERFLOW_FLAG_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional macro CLA_OVERFLOW_FLAG_EN registers a signed-overflow flag next to sum.
module pipelined_cla_adder #(
    parameter int WIDTH   = 6,
    parameter int GROUP_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NG       = (WIDTH + GROUP_W - 1) / GROUP_W;
    localparam int LAST_LEN = WIDTH - (NG - 1) * GROUP_W;

    logic [WIDTH-1:0] g_q, p_q, h_q;
    logic             c0_q;
    logic             s1_valid_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] bb;
    logic             c0;
    logic             s1_adv;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign bb     = bus.sub ? ~bus.b : bus.b;
    assign c0     = bus.sub | bus.cin;
    assign s1_adv = s1_valid_q & (~out_valid_q | bus.out_ready);
    assign in_ready = ~s1_valid_q | s1_adv;
    assign accept = bus.in_valid & in_ready;

    // Each group computes all its internal carries directly from g/p and the
    // group carry-in; only the group carry-outs chain from group to group.
    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int BASE = gi * GROUP_W;
            localparam int LEN  = (WIDTH - BASE < GROUP_W) ? (WIDTH - BASE) : GROUP_W;

            logic           cin_g;
            logic [LEN:0]   cc;
            logic           term;
            logic           pp;

            if (gi == 0) begin : g_first
                assign cin_g = c0_q;
            end else begin : g_next
                assign cin_g = g_grp[gi-1].cc[GROUP_W];
            end

            always_comb begin
                cc    = '0;
                term  = 1'b0;
                pp    = 1'b1;
                cc[0] = cin_g;
                for (int j = 0; j < LEN; j++) begin
                    term = 1'b0;
                    pp   = 1'b1;
                    for (int m = j; m >= 0; m--) begin
                        term = term | (g_q[BASE+m] & pp);
                        pp   = pp & p_q[BASE+m];
                    end
                    cc[j+1] = term | (pp & cin_g);
                end
            end

            assign sum_d[BASE +: LEN] = h_q[BASE +: LEN] ^ cc[LEN-1:0];
        end
    endgenerate

    assign cout_d = g_grp[NG-1].cc[LAST_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q         <= '0;
            p_q         <= '0;
            h_q         <= '0;
            c0_q        <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            if (accept) begin
                g_q        <= bus.a & bb;
                p_q        <= bus.a | bb;
                h_q        <= bus.a ^ bb;
                c0_q       <= c0;
                s1_valid_q <= 1'b1;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                out_valid_q <= 1'b1;
                sum_q       <= sum_d;
                cout_q      <= cout_d;
            end else if (out_valid_q & bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef CLA_OVERFLOW_FLAG_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB differing from carry out of it marks signed overflow.
    assign ovf_d = cout_d ^ g_grp[NG-1].cc[LAST_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s1_adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised carry-lookahead adder/subtractor built from per-bit generate/propagate/half-sum terms (g = x&y, p = x|y, h = x^y).
- Two-stage pipeline with valid/ready handshake on input and output.
- Successor to the fixed 6-bit combinational adder; sits between an operand source and a result consumer in the datapath test harness.

Parameters:
- WIDTH, 6, operand and sum width in bits (>=2).
- GROUP_W, 3, bits per lookahead group. The last group is shorter if WIDTH is not a multiple of GROUP_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- sub  in  1  1 = A - B (B inverted, carry-in forced to 1, cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out. For subtraction, 1 = no borrow.

Behaviour:
- Reset is asynchronous active-low. While rst_n=0: s1_valid=0, out_valid=0, sum=0, cout=0, and all stage-1 registers are 0.
- in_ready = !s1_valid | s1_adv is combinational. It is high after reset.
- Stage 1 captures on in_valid & in_ready. It registers:
  - bb = sub ? ~b : b
  - c0 = sub ? 1 : cin
  - per-bit g[i] = a[i]&bb[i], p[i] = a[i]|bb[i], h[i] = a[i]^bb[i]
  - s1_valid = 1
- Stage 1 advances: s1_adv = s1_valid & (!out_valid | out_ready).
- Stage 2 (registered output), within each group:
  - c[i+1] = g[i] | p[i]&c[i], expanded as two-level lookahead (no in-group ripple).
  - Group carry-out feeds the next group's carry-in.
  - sum[i] = h[i]^c[i]; cout = c[WIDTH].
- out_valid rules:
  - Set on s1_adv.
  - Cleared when out_valid & out_ready & !s1_adv.
  - Held with sum/cout stable while out_ready=0.
- Latency: 2 clk from accepted input to out_valid.
- Throughput: 1 beat/clk when out_ready is held high.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0 and no data is lost or duplicated.
  - Simultaneous output pop and stage-1 advance in the same cycle replaces the output with no bubble.
  - Simultaneous stage-1 advance and new input capture in the same cycle is legal.
- Arithmetic is modulo 2^WIDTH. Wrap-around appears only in cout. Carry-in is honoured at bit 0 of the first group.
- rst_n asserted mid-operation flushes all in-flight beats. No result is emitted for them after release.
- Inputs a, b, cin and sub are sampled only on the accept cycle. Changes while in_ready=0 have no effect.

Optional Feature:
- Macro: CLA_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port ovf (out, 1), reset 0.
  - ovf = c[WIDTH] ^ c[WIDTH-1] (signed two's-complement overflow of the performed operation).
  - Registered alongside sum, same valid/hold rules as sum.
- Undefined: no ovf port; no extra logic.

Test Plan (WIDTH=6, GROUP_W=3):
1. Reset with rst_n=0, then release → out_valid=0, sum=0, cout=0, in_ready=1. Then a=21, b=13, cin=0, sub=0, one beat → exactly 2 clk later out_valid=1, sum=34, cout=0.
2. a=63, b=1, cin=1, sub=0 → sum=1, cout=1. a=63, b=0, cin=1 → sum=0, cout=1 (full carry chain across both groups).
3. sub=1: a=10, b=3 → sum=7, cout=1. a=3, b=10 → sum=57, cout=0. With CLA_OVERFLOW_FLAG_EN: a=31, b=63 (−1), sub=1 → sum=32, ovf=1.
4. Stream of 8 back-to-back beats a=k, b=k for k=0..7, out_ready=1 → 8 consecutive valid cycles, sum=2k in order.
5. Backpressure: out_ready=0 for 5 clk during the stream of test 4 → in_ready falls after 2 accepted beats, sum is held stable, no beat is lost; after out_ready=1 the remaining results arrive in order.
6. rst_n pulsed low for one cycle while two beats are in flight → out_valid=0 immediately, no stale result after release, next beat a=5, b=6 yields sum=11.
